// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: edge-FSM state encoding,
// default duty resolution and counter-width helper.
package pwm_pkg;

   // Default duty resolution N; the measurement window is 2**N CE ticks.
   localparam int PWM_IN_SIZE_DEFAULT = 10;

   // Edge tracking states: waiting for a first rise, inside the high part,
   // inside the low part of a cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } edge_state_t;

   // Period/high-width counters need one bit more than the duty value so a
   // full cycle of 2**N ticks (and longer) stays representable.
   function automatic int cnt_width(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Brings the asynchronous PWM waveform into the clk_in domain, optionally
// glitch-filters it, and produces the CE-sampled level plus rise/fall strobes.
// Optional feature macro: PWM_GLITCH_FILTER_EN (majority vote over the last
// FILTER_LEN synchronised CE samples).
module pwm_input_sync
   import pwm_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk_in,
   input  logic reset_n_in,
   input  logic synch_clear_in,
   input  logic CE_in,
   input  logic pwm_in,
   output logic sample_level,
   output logic rise,
   output logic fall
);

   // Parameter sanity: illegal values stop elaboration.
   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("pwm_input_sync: SYNC_STAGES must be >= 2");
      end
      if ((FILTER_LEN < 3) || (FILTER_LEN > 7) || ((FILTER_LEN % 2) == 0)) begin : g_bad_filter
         $error("pwm_input_sync: FILTER_LEN must be odd and within 3..7");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   synced;
   logic                   sample;
   logic                   level_reg;

   // Synchroniser runs every clock; the clear leaves it alone so the
   // waveform is already settled when measurement restarts.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], pwm_in};
      end
   end

   assign synced = sync_chain[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
   logic [FILTER_LEN-2:0] hist;
   int                    votes;

   // History of previous synchronised CE samples, newest in bit 0.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         hist <= '0;
      end else if (synch_clear_in) begin
         hist <= '0;
      end else if (CE_in) begin
         hist <= {hist[FILTER_LEN-3:0], synced};
      end
   end

   // Majority vote over the current synchronised value and the history.
   always_comb begin
      votes = int'(synced);
      for (int i = 0; i < FILTER_LEN - 1; i++) begin
         votes = votes + int'(hist[i]);
      end
      sample = (votes > (FILTER_LEN / 2));
   end
`else
   assign sample = synced;
`endif

   // Level as seen at the previous CE tick; edges compare against it.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         level_reg <= 1'b0;
      end else if (synch_clear_in) begin
         level_reg <= 1'b0;
      end else if (CE_in) begin
         level_reg <= sample;
      end
   end

   assign sample_level = sample;
   assign rise         = CE_in &  sample & ~level_reg;
   assign fall         = CE_in & ~sample &  level_reg;

endmodule

// File: rtl/pwm_duty_capture.sv
// PWM receive side: recovers the duty value over a free-running 2**N tick
// window and measures edge-to-edge high width / period of each cycle.
// Optional feature macro: PWM_GLITCH_FILTER_EN (handled in pwm_input_sync).
module pwm_duty_capture
   import pwm_pkg::*;
#(
   parameter int PWM_IN_SIZE = PWM_IN_SIZE_DEFAULT,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic                   clk_in,
   input  logic                   reset_n_in,
   input  logic                   synch_clear_in,
   input  logic                   CE_in,
   input  logic                   pwm_in,
   output logic [PWM_IN_SIZE-1:0] duty_out,
   output logic                   duty_valid_out,
   output logic [PWM_IN_SIZE:0]   high_width_out,
   output logic [PWM_IN_SIZE:0]   period_out,
   output logic                   pulse_valid_out,
   output logic                   stuck_high_out,
   output logic                   stuck_low_out,
   output logic                   timeout_out
);

   localparam int              N        = PWM_IN_SIZE;
   localparam int              CW       = cnt_width(PWM_IN_SIZE);
   localparam logic [N-1:0]    WIN_LAST = '1;
   localparam logic [N-1:0]    WIN_ONE  = N'(1);
   localparam logic [CW-1:0]   CNT_MAX  = '1;
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   WIN_FULL = CW'(1) << N;

   logic          level;
   logic          rise;
   logic          fall;

   logic [N-1:0]  win_cnt;
   logic [CW-1:0] acc;
   logic [CW-1:0] win_total;

   edge_state_t   state_reg;
   edge_state_t   state_next;
   logic [CW-1:0] hcnt_reg;
   logic [CW-1:0] hcnt_next;
   logic [CW-1:0] pcnt_reg;
   logic [CW-1:0] pcnt_next;
   logic          publish;
   logic          timeout_hit;

   pwm_input_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sync (
      .clk_in         (clk_in),
      .reset_n_in     (reset_n_in),
      .synch_clear_in (synch_clear_in),
      .CE_in          (CE_in),
      .pwm_in         (pwm_in),
      .sample_level   (level),
      .rise           (rise),
      .fall           (fall)
   );

   // The closing tick's own sample still belongs to the window it closes.
   assign win_total = acc + {{N{1'b0}}, level};

   // Window accumulator: count high samples over 2**N CE ticks, publish on wrap.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         win_cnt        <= '0;
         acc            <= '0;
         duty_out       <= '0;
         duty_valid_out <= 1'b0;
         stuck_high_out <= 1'b0;
         stuck_low_out  <= 1'b0;
      end else if (synch_clear_in) begin
         win_cnt        <= '0;
         acc            <= '0;
         duty_out       <= '0;
         duty_valid_out <= 1'b0;
         stuck_high_out <= 1'b0;
         stuck_low_out  <= 1'b0;
      end else begin
         duty_valid_out <= 1'b0;
         if (CE_in) begin
            win_cnt <= win_cnt + WIN_ONE;
            if (win_cnt == WIN_LAST) begin
               // A fully-high window is 2**N, one more than duty_out can hold.
               duty_out       <= win_total[N] ? '1 : win_total[N-1:0];
               stuck_high_out <= (win_total == WIN_FULL);
               stuck_low_out  <= (win_total == '0);
               duty_valid_out <= 1'b1;
               acc            <= '0;
            end else begin
               acc <= win_total;
            end
         end
      end
   end

   // Edge FSM state and cycle counters.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_reg <= ST_IDLE;
         hcnt_reg  <= '0;
         pcnt_reg  <= '0;
      end else if (synch_clear_in) begin
         state_reg <= ST_IDLE;
         hcnt_reg  <= '0;
         pcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         hcnt_reg  <= hcnt_next;
         pcnt_reg  <= pcnt_next;
      end
   end

   // Edge FSM next state: timeout has priority over a rise arriving on the
   // same tick, so a saturated period is never published.
   always_comb begin
      state_next  = state_reg;
      hcnt_next   = hcnt_reg;
      pcnt_next   = pcnt_reg;
      publish     = 1'b0;
      timeout_hit = 1'b0;
      if (CE_in) begin
         case (state_reg)
            ST_IDLE: begin
               if (rise) begin
                  state_next = ST_HIGH;
                  hcnt_next  = CNT_ONE;
                  pcnt_next  = CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (pcnt_reg == CNT_MAX) begin
                  timeout_hit = 1'b1;
                  state_next  = ST_IDLE;
                  hcnt_next   = '0;
                  pcnt_next   = '0;
               end else if (fall) begin
                  state_next = ST_LOW;
                  pcnt_next  = pcnt_reg + CNT_ONE;
               end else begin
                  hcnt_next = hcnt_reg + CNT_ONE;
                  pcnt_next = pcnt_reg + CNT_ONE;
               end
            end
            ST_LOW: begin
               if (pcnt_reg == CNT_MAX) begin
                  timeout_hit = 1'b1;
                  state_next  = ST_IDLE;
                  hcnt_next   = '0;
                  pcnt_next   = '0;
               end else if (rise) begin
                  publish    = 1'b1;
                  state_next = ST_HIGH;
                  hcnt_next  = CNT_ONE;
                  pcnt_next  = CNT_ONE;
               end else begin
                  pcnt_next = pcnt_reg + CNT_ONE;
               end
            end
            default: begin
               state_next = ST_IDLE;
               hcnt_next  = '0;
               pcnt_next  = '0;
            end
         endcase
      end
   end

   // Pulse measurement outputs and the sticky timeout flag.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         high_width_out  <= '0;
         period_out      <= '0;
         pulse_valid_out <= 1'b0;
         timeout_out     <= 1'b0;
      end else if (synch_clear_in) begin
         high_width_out  <= '0;
         period_out      <= '0;
         pulse_valid_out <= 1'b0;
         timeout_out     <= 1'b0;
      end else begin
         pulse_valid_out <= publish;
         if (publish) begin
            high_width_out <= hcnt_reg;
            period_out     <= pcnt_reg;
         end
         if (timeout_hit) begin
            timeout_out <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomised bench for pwm_duty_capture (N=10, SYNC_STAGES=2, FILTER_LEN=3).
// The reference keeps the CE-sampled level sequence as plain indices and sums;
// every valid pulse from the DUT is matched against the queued expectation.
module tb_pwm_duty_capture;

   localparam int N    = 10;
   localparam int WIN  = 1 << N;
   localparam int PMAX = (1 << (N + 1)) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         ce;
   logic         pwm;
   logic [N-1:0] duty;
   logic         duty_valid;
   logic [N:0]   hw;
   logic [N:0]   per;
   logic         pv;
   logic         sh;
   logic         sl;
   logic         to;

   always #5 clk = ~clk;

   pwm_duty_capture #(
      .PWM_IN_SIZE (N),
      .SYNC_STAGES (2),
      .FILTER_LEN  (3)
   ) dut (
      .clk_in          (clk),
      .reset_n_in      (rst_n),
      .synch_clear_in  (clr),
      .CE_in           (ce),
      .pwm_in          (pwm),
      .duty_out        (duty),
      .duty_valid_out  (duty_valid),
      .high_width_out  (hw),
      .period_out      (per),
      .pulse_valid_out (pv),
      .stuck_high_out  (sh),
      .stuck_low_out   (sl),
      .timeout_out     (to)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int duty; bit sh; bit sl; } win_t;
   typedef struct { int hw; int per; } pulse_t;

   win_t   exp_win[$];
   pulse_t exp_pulse[$];
   int     samp_cnt, win_sum, last_rise, first_fall;
   bit     prev_s, h0, h1, fa, fb;
   int     last_duty, last_hw, last_per;
   bit     last_sh, last_sl, exp_to;

   function void model_reset();
      exp_win.delete();
      exp_pulse.delete();
      samp_cnt   = 0;
      win_sum    = 0;
      last_rise  = -1;
      first_fall = -1;
      prev_s     = 0;
      fa         = 0;
      fb         = 0;
      last_duty  = 0;
      last_hw    = 0;
      last_per   = 0;
      last_sh    = 0;
      last_sl    = 0;
      exp_to     = 0;
   endfunction

   // One CE sample: index idx counts samples since reset/clear.
   function void model_sample(input bit s);
      win_t   w;
      pulse_t p;
      int     idx;
      idx     = samp_cnt;
      win_sum = win_sum + int'(s);
      if (idx % WIN == WIN - 1) begin
         w.duty = (win_sum > WIN - 1) ? WIN - 1 : win_sum;
         w.sh   = (win_sum == WIN);
         w.sl   = (win_sum == 0);
         exp_win.push_back(w);
         last_duty = w.duty;
         last_sh   = w.sh;
         last_sl   = w.sl;
         win_sum   = 0;
      end
      if (last_rise >= 0 && idx - last_rise == PMAX) begin
         exp_to    = 1;
         last_rise = -1;
      end else if (s && !prev_s) begin
         if (last_rise >= 0) begin
            p.hw  = first_fall - last_rise;
            p.per = idx - last_rise;
            exp_pulse.push_back(p);
            last_hw  = p.hw;
            last_per = p.per;
         end
         last_rise  = idx;
         first_fall = -1;
      end else if (!s && prev_s && last_rise >= 0 && first_fall < 0) begin
         first_fall = idx;
      end
      prev_s   = s;
      samp_cnt = samp_cnt + 1;
   endfunction

   // h1 is the pwm level seen two edges back: that is what reaches the sampler.
   always @(posedge clk or negedge rst_n) begin : model
      bit s_now;
      if (!rst_n) begin
         model_reset();
         h0 = 0;
         h1 = 0;
      end else begin
         if (clr) begin
            model_reset();
         end else if (ce) begin
`ifdef PWM_GLITCH_FILTER_EN
            s_now = ((int'(h1) + int'(fa) + int'(fb)) >= 2);
            fb    = fa;
            fa    = h1;
`else
            s_now = h1;
`endif
            model_sample(s_now);
         end
         h1 = h0;
         h0 = pwm;
      end
   end

   // Match each DUT valid pulse with the model's queued expectation.
   always @(negedge clk) begin : mon
      win_t   w;
      pulse_t p;
      if (rst_n) begin
         if (duty_valid) begin
            if (exp_win.size() > 0) begin
               w = exp_win.pop_front();
               $display("[TB] window duty=%0d sh=%0d sl=%0d (exp %0d/%0d/%0d)", duty, sh, sl, w.duty, w.sh, w.sl);
               check_val("win_duty", 32'(duty), 32'(w.duty));
               check_val("win_stuck_high", 32'(sh), 32'(w.sh));
               check_val("win_stuck_low", 32'(sl), 32'(w.sl));
            end else begin
               check_val("duty_valid_spurious", 32'd1, 32'd0);
            end
         end
         if (pv) begin
            if (exp_pulse.size() > 0) begin
               p = exp_pulse.pop_front();
               check_val("pulse_high_width", 32'(hw), 32'(p.hw));
               check_val("pulse_period", 32'(per), 32'(p.per));
            end else begin
               check_val("pulse_valid_spurious", 32'd1, 32'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int gen_cnt = 0;

   // Generator: counter of CE ticks, output high while below data.
   // ce_div 0 means CE randomly on about half the clocks.
   task automatic run_pwm(input int data, input int n_clk, input int ce_div);
      for (int i = 0; i < n_clk; i++) begin
         @(posedge clk);
         #1;
         if (ce_div == 0) ce = 1'($urandom_range(0, 1));
         else             ce = ((i % ce_div) == 0);
         if (ce) gen_cnt = (gen_cnt + 1) % WIN;
         pwm = (gen_cnt < data);
      end
   endtask

   // Random run-length noise on pwm with mostly-on CE.
   task automatic run_noise(input int n_clk);
      int run;
      run = 0;
      for (int i = 0; i < n_clk; i++) begin
         @(posedge clk);
         #1;
         ce = ($urandom_range(0, 3) != 0);
         if (run == 0) begin
            pwm = ~pwm;
            run = $urandom_range(1, 40);
         end else begin
            run--;
         end
      end
   endtask

   task automatic do_clear();
      @(posedge clk);
      #1;
      clr = 1'b1;
      ce  = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check_val("clr_duty", 32'(duty), 32'd0);
      check_val("clr_timeout", 32'(to), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_duty"}, 32'(duty), 32'd0);
      check_val({tag, "_duty_valid"}, 32'(duty_valid), 32'd0);
      check_val({tag, "_high_width"}, 32'(hw), 32'd0);
      check_val({tag, "_period"}, 32'(per), 32'd0);
      check_val({tag, "_pulse_valid"}, 32'(pv), 32'd0);
      check_val({tag, "_stuck"}, 32'({sh, sl}), 32'd0);
      check_val({tag, "_timeout"}, 32'(to), 32'd0);
   endtask

   task automatic check_end(input string tag);
      @(negedge clk);
      #1;
      $display("[TB] %s: duty=%0d hw=%0d per=%0d sh=%0d sl=%0d to=%0d", tag, duty, hw, per, sh, sl, to);
      check_val({tag, "_duty"}, 32'(duty), 32'(last_duty));
      check_val({tag, "_stuck_high"}, 32'(sh), 32'(last_sh));
      check_val({tag, "_stuck_low"}, 32'(sl), 32'(last_sl));
      check_val({tag, "_high_width"}, 32'(hw), 32'(last_hw));
      check_val({tag, "_period"}, 32'(per), 32'(last_per));
      check_val({tag, "_timeout"}, 32'(to), 32'(exp_to));
      check_val({tag, "_win_pending"}, 32'(exp_win.size()), 32'd0);
      check_val({tag, "_pulse_pending"}, 32'(exp_pulse.size()), 32'd0);
   endtask

   initial begin
      int data;
      rst_n = 1'b0;
      clr   = 1'b0;
      ce    = 1'b0;
      pwm   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;

      // Looped generator, data=300, CE every clock.
      gen_cnt = $urandom_range(0, WIN - 1);
      run_pwm(300, 3 * WIN + 50, 1);
      check_end("d300");
      check_val("d300_duty_abs", 32'(duty), 32'd300);
      check_val("d300_hw_abs", 32'(hw), 32'd300);
      check_val("d300_per_abs", 32'(per), 32'd1024);

      // Random duty values, phase continues from the previous run.
      for (int k = 0; k < 3; k++) begin
         data = $urandom_range(1, WIN - 2);
         run_pwm(data, 2 * WIN + 20, 1);
         check_end("drand");
         check_val("drand_duty_abs", 32'(duty), 32'(data));
      end

      // data=0: all-low windows.
      do_clear();
      run_pwm(0, 2600, 1);
      check_end("d0");
      check_val("d0_duty_abs", 32'(duty), 32'd0);
      check_val("d0_stuck_low_abs", 32'(sl), 32'd1);

      // Constant high input.
      do_clear();
      run_pwm(WIN, 2200, 1);
      check_end("dhigh");
      check_val("dhigh_duty_abs", 32'(duty), 32'd1023);
      check_val("dhigh_stuck_high_abs", 32'(sh), 32'd1);
      check_val("dhigh_timeout_abs", 32'(to), 32'd1);

      // CE every 4th clock, data=512.
      do_clear();
      gen_cnt = $urandom_range(0, WIN - 1);
      run_pwm(512, 3 * 4 * WIN + 40, 4);
      check_end("ce4");
      check_val("ce4_duty_abs", 32'(duty), 32'd512);

      // Irregular CE with a random duty value.
      run_pwm($urandom_range(1, WIN - 2), 4500, 0);
      check_end("cerand");

      // Run-length noise: many short cycles.
      run_noise(3000);
      check_end("noise");

      // Asynchronous reset in the middle of a window.
      run_pwm(700, 500, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_pwm(700, WIN + 30, 1);
      check_end("after_reset");

      // One-sample spike on a low input.
      pwm = 1'b0;
      run_pwm(0, 5, 1);
      do_clear();
      run_pwm(0, 300, 1);
      @(posedge clk);
      #1;
      ce  = 1'b1;
      pwm = 1'b1;
      @(posedge clk);
      #1;
      pwm = 1'b0;
      run_pwm(0, WIN, 1);
      check_end("spike");
`ifdef PWM_GLITCH_FILTER_EN
      check_val("spike_duty_abs", 32'(duty), 32'd0);
`else
      check_val("spike_duty_abs", 32'(duty), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
